// File: rtl/flt2fix_pkg.sv
// Shared types and constants for the float16 -> signed 8.8 fixed-point converter.
package flt2fix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_LO  = 3'd1,
    ST_RD_HI  = 3'd2,
    ST_DECODE = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_FIX    = 3'd5,
    ST_WR_LO  = 3'd6,
    ST_WR_HI  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_ZERO  = 3'd0,
    CL_INF   = 3'd1,
    CL_NAN   = 3'd2,
    CL_SAT   = 3'd3,
    CL_LEFT  = 3'd4,
    CL_RIGHT = 3'd5
  } class_t;

  localparam int BIAS      = 15;
  // sig (1.10) scaled by 2^8 lands exactly on the 8.8 grid at this exponent
  localparam int E_UNITY   = BIAS + 2;
  localparam int E_SAT     = 22;
  localparam int SHIFT_CAP = 11;

  localparam logic [15:0] MAX_POS = 16'h7FFF;
  localparam logic [15:0] MAX_NEG = 16'h8000;

  function automatic logic [15:0] sat_value(input logic s);
    return s ? MAX_NEG : MAX_POS;
  endfunction

endpackage

// File: rtl/flt16_classify.sv
// Combinational float16 field decode: sign, exponent, significand, class and shift count.
module flt16_classify
  import flt2fix_pkg::*;
(
  input  logic [15:0] operand,
  output logic        s,
  output logic [4:0]  e,
  output logic [10:0] sig,
  output class_t      cls,
  output logic [3:0]  shift_n
);

  logic [9:0] m;
  logic [4:0] right_dist;

  assign s   = operand[15];
  assign e   = operand[14:10];
  assign m   = operand[9:0];
  assign sig = {1'b1, m};

  // Only meaningful when e < E_UNITY (right-shift region).
  assign right_dist = 5'(E_UNITY) - e;

  always_comb begin
    cls     = CL_ZERO;
    shift_n = '0;
    if (e == 5'd0) begin
      cls = CL_ZERO;
    end else if (e == 5'd31) begin
      cls = (m != '0) ? CL_NAN : CL_INF;
    end else if (e >= 5'(E_SAT)) begin
      cls = CL_SAT;
    end else if (e >= 5'(E_UNITY)) begin
      cls     = CL_LEFT;
      shift_n = 4'(e - 5'(E_UNITY));
    end else begin
      cls     = CL_RIGHT;
      // Beyond SHIFT_CAP every significand bit has fallen off anyway.
      shift_n = (right_dist > 5'(SHIFT_CAP)) ? 4'(SHIFT_CAP) : right_dist[3:0];
    end
  end

endmodule

// File: rtl/flt2fix_engine.sv
// float16 -> signed 8.8 converter on a byte-wide memory port, one shift bit per cycle.
// Handshake: start is sampled only in IDLE; done is a level set at the end of WR_HI and cleared when the next start is accepted.
module flt2fix_engine
  import flt2fix_pkg::*;
#(
  parameter int SRC_ADDR = 2,
  parameter int DST_ADDR = 4,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output state_t        dbg_state
);

  state_t      state, state_nx;
  logic        start_q;
  logic [7:0]  lo_q, hi_q;
  logic        sign_q;
  class_t      cls_q;
  logic        left_q;
  logic [15:0] mag;
  logic [3:0]  cnt;
  logic [15:0] result;
  logic [15:0] fix_result;

  logic        c_s;
  logic [4:0]  c_e;
  logic [10:0] c_sig;
  class_t      c_cls;
  logic [3:0]  c_shift_n;

  flt16_classify u_classify (
    .operand (({hi_q, lo_q})),
    .s       (c_s),
    .e       (c_e),
    .sig     (c_sig),
    .cls     (c_cls),
    .shift_n (c_shift_n)
  );

  assign dbg_state = state;

  // Accepted start is registered, so RD_LO begins one cycle after the sampling edge.
  logic accept;
  assign accept = (state == ST_IDLE) && !start_q && start;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (start_q) state_nx = ST_RD_LO;
      ST_RD_LO:  state_nx = ST_RD_HI;
      ST_RD_HI:  state_nx = ST_DECODE;
      ST_DECODE: state_nx = (c_shift_n != '0) ? ST_SHIFT : ST_FIX;
      ST_SHIFT:  if (cnt == 4'd1) state_nx = ST_FIX;
      ST_FIX:    state_nx = ST_WR_LO;
      ST_WR_LO:  state_nx = ST_WR_HI;
      ST_WR_HI:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    unique case (state)
      ST_RD_LO: mem_addr = AW'(SRC_ADDR);
      ST_RD_HI: mem_addr = AW'(SRC_ADDR + 1);
      ST_WR_LO: begin
        mem_addr    = AW'(DST_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = result[7:0];
      end
      ST_WR_HI: begin
        mem_addr    = AW'(DST_ADDR + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = result[15:8];
      end
      default: ;
    endcase
  end

  // Negating an in-range magnitude never overflows: left shifts top out at 0x7FF0.
  always_comb begin
    fix_result = '0;
    unique case (cls_q)
      CL_ZERO:           fix_result = '0;
      CL_NAN:            fix_result = MAX_POS;
      CL_INF, CL_SAT:    fix_result = sat_value(sign_q);
      CL_LEFT, CL_RIGHT: fix_result = sign_q ? (16'd0 - mag) : mag;
      default:           fix_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      done    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      sign_q  <= 1'b0;
      cls_q   <= CL_ZERO;
      left_q  <= 1'b0;
      mag     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      state   <= state_nx;
      start_q <= accept;
      if (accept) done <= 1'b0;
      unique case (state)
        ST_RD_LO: lo_q <= mem_rd_data;
        ST_RD_HI: hi_q <= mem_rd_data;
        ST_DECODE: begin
          sign_q <= c_s;
          cls_q  <= c_cls;
          left_q <= (c_e >= 5'(E_UNITY));
          mag    <= {5'b0, c_sig};
          cnt    <= c_shift_n;
        end
        ST_SHIFT: begin
          mag <= left_q ? {mag[14:0], 1'b0} : {1'b0, mag[15:1]};
          cnt <= cnt - 4'd1;
        end
        ST_FIX:   result <= fix_result;
        ST_WR_HI: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2fix_engine.sv
// Bench for flt2fix_engine: byte memory model, write scoreboard, arithmetic reference model.
module tb_flt2fix_engine;
  import flt2fix_pkg::*;

  localparam int SRC = 2;
  localparam int DST = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  state_t        dbg_state;

  logic [7:0]    mem [256];
  logic          tb_we;
  logic [7:0]    tb_addr;
  logic [7:0]    tb_data;

  logic [15:0]   exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          done_exp;

  flt2fix_engine #(.SRC_ADDR(SRC), .DST_ADDR(DST), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_fix(input logic [15:0] f);
    int e, sig, mag, v;
    e   = int'(f[14:10]);
    sig = 1024 + int'(f[9:0]);
    if (e == 0) return 16'h0000;
    if (e == 31) return (f[9:0] != 0 || !f[15]) ? 16'h7FFF : 16'h8000;
    // value * 256 = sig * 2^(e-17)
    if (e >= 17) mag = sig << (e - 17);
    else         mag = sig >> (17 - e);
    if (f[15]) begin
      v = -mag;
      return (v < -32768) ? 16'h8000 : 16'(v);
    end
    return (mag > 32767) ? 16'h7FFF : 16'(mag);
  endfunction

  function automatic int ref_n(input logic [15:0] f);
    int e;
    e = int'(f[14:10]);
    if (e == 0 || e == 31 || e >= 22) return 0;
    if (e >= 17) return e - 17;
    return (17 - e > 11) ? 11 : 17 - e;
  endfunction

  // The companion core's 8.8 -> float16 conversion (truncating).
  function automatic logic [15:0] fix_to_f16(input logic [15:0] x);
    int a, p, sig;
    logic s;
    if (x == 16'h0000) return 16'h0000;
    s = x[15];
    a = s ? 65536 - int'(x) : int'(x);
    p = 0;
    for (int i = 0; i < 17; i++) if (((a >> i) & 1) != 0) p = i;
    sig = (p >= 10) ? (a >> (p - 10)) : (a << (10 - p));
    return {s, 5'(p + 7), 10'(sig & 1023)};
  endfunction

  function automatic logic [15:0] trunc_fix(input logic [15:0] x);
    int a, p;
    if (x == 16'h0000) return 16'h0000;
    a = x[15] ? 65536 - int'(x) : int'(x);
    p = 0;
    for (int i = 0; i < 17; i++) if (((a >> i) & 1) != 0) p = i;
    if (p > 10) a = (a >> (p - 10)) << (p - 10);
    return x[15] ? 16'(-a) : 16'(a);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr=%0h data=%0h, required no write", mem_addr, mem_wr_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if ({mem_addr, mem_wr_data} !== e) begin
            n_err++;
            $display("FAIL write: addr/data=%04h, required %04h", {mem_addr, mem_wr_data}, e);
          end
        end
      end
      if (dbg_state == ST_IDLE) begin
        n_vec++;
        if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_wr_data !== '0) begin
          n_err++;
          $display("FAIL idle_outputs: en=%0b addr=%0h data=%0h, required 0 0 0", mem_wr_en, mem_addr, mem_wr_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = 8'(a); tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic convert(input logic [15:0] op, input logic [15:0] exp_res, input int exp_n,
                         input int glitch_at, input string tag);
    int cyc;
    poke(SRC, op[7:0]);
    poke(SRC + 1, op[15:8]);
    poke(DST, 8'hA5);
    poke(DST + 1, 8'h5A);
    chk({tag, "_done_hold"}, 32'(done), 32'(done_exp));
    exp_q.push_back({8'(DST), exp_res[7:0]});
    exp_q.push_back({8'(DST + 1), exp_res[15:8]});
    @(negedge clk); start = 1'b1;
    @(posedge clk);                     // T0: start sampled
    @(negedge clk); start = 1'b0;
    chk({tag, "_done_clear"}, 32'(done), 0);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (glitch_at != 0 && cyc == glitch_at);
    end
    start = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", tag, cyc);
    end else begin
      chk({tag, "_latency"}, 32'(cyc), 32'(7 + exp_n));
    end
    chk({tag, "_result"}, {16'h0, mem[DST + 1], mem[DST]}, {16'h0, exp_res});
    done_exp = 1'b1;
  endtask

  task automatic directed(input logic [15:0] op, input logic [15:0] lit, input int n_lit, input string tag);
    chk({tag, "_model"}, {16'h0, ref_fix(op)}, {16'h0, lit});
    chk({tag, "_model_n"}, 32'(ref_n(op)), 32'(n_lit));
    convert(op, lit, n_lit, 0, tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    logic [15:0] x, f;
    reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    done_exp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wr_data", 32'(mem_wr_data), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    directed(16'h3C00, 16'h0100, 2, "one");
    directed(16'h4400, 16'h0400, 0, "four");
    directed(16'hBC00, 16'hFF00, 2, "neg_one");
    directed(16'h3E00, 16'h0180, 2, "one_half");
    directed(16'h57FF, 16'h7FF0, 4, "max_left");
    directed(16'h1C00, 16'h0001, 10, "lsb");
    directed(16'h1800, 16'h0000, 11, "below_lsb");
    directed(16'h5800, 16'h7FFF, 0, "sat_pos");
    directed(16'hD800, 16'h8000, 0, "sat_neg");
    directed(16'h7C00, 16'h7FFF, 0, "inf_pos");
    directed(16'hFC00, 16'h8000, 0, "inf_neg");
    directed(16'h7E00, 16'h7FFF, 0, "nan");
    directed(16'h8000, 16'h0000, 0, "neg_zero");

    // Extra start mid-conversion must not produce a second write pair.
    convert(16'h3E00, 16'h0180, 2, 3, "glitch");
    repeat (20) @(negedge clk);
    chk("glitch_queue", 32'(exp_q.size()), 0);

    // Reset while shifting: no writes, then a clean conversion.
    poke(SRC, 8'h00); poke(SRC + 1, 8'h3C); poke(DST, 8'hA5); poke(DST + 1, 8'h5A);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (dbg_state != ST_SHIFT && cyc < 20) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk("rst_reach_shift", 32'(dbg_state), 32'(ST_SHIFT));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_mid_done", 32'(done), 0);
    done_exp = 1'b0;
    repeat (15) @(negedge clk);
    chk("rst_mid_no_write", {16'h0, mem[DST + 1], mem[DST]}, 32'h5AA5);
    convert(16'h3C00, 16'h0100, 2, 0, "after_rst");

    // Random raw float16 operands.
    for (int i = 0; i < 40; i++) begin
      f = 16'($urandom_range(0, 65535));
      convert(f, ref_fix(f), ref_n(f), 0, "rand_f16");
    end

    // Round trip through the core's truncating 8.8 -> float16 conversion.
    for (int i = 0; i < 100; i++) begin
      x = 16'($urandom_range(0, 65535));
      f = fix_to_f16(x);
      convert(f, trunc_fix(x), ref_n(f), 0, "round_trip");
    end

    repeat (10) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
